mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-lane RAM between the core's instruction-fetch port and its load/store port.
//  Round-robin grant; one transaction in flight at a time.
//  Translates byte address + access size into word address, byte enables and lane-shifted write data.
//  Returns sign-/zero-extended load data. Sits between the RV32I core and the ram block.
// PARAMETERS
//  XLEN        32  data/address width of core ports
//  RAM_AWIDTH  5   RAM word-address bits; RAM word address = byte_addr[RAM_AWIDTH+1:2], upper bits ignored
// PORTS
//  clk              in   1           clock
//  rst              in   1           asynchronous, active-high reset
//  clk_en           in   1           global clock enable; no state changes when low
//  i_if_req_valid   in   1           fetch request valid
//  o_if_req_ready   out  1           fetch request accepted
//  i_if_req_addr    in   XLEN        fetch byte address (word access)
//  o_if_rsp_valid   out  1           fetch data valid
//  i_if_rsp_ready   in   1           fetch data consumed
//  o_if_rsp_rdata   out  XLEN        fetched word
//  i_d_req_valid    in   1           load/store request valid
//  o_d_req_ready    out  1           load/store request accepted
//  i_d_req_we       in   1           1=store, 0=load
//  i_d_req_addr     in   XLEN        byte address
//  i_d_req_size     in   2           0=byte 1=half 2=word (3 treated as word)
//  i_d_req_unsigned in   1           loads: zero-extend (LBU/LHU)
//  i_d_req_wdata    in   XLEN        store data, right-aligned
//  o_d_rsp_valid    out  1           load data / store completion valid
//  i_d_rsp_ready    in   1           response consumed
//  o_d_rsp_rdata    out  XLEN        extended load data (0 for stores)
//  o_d_rsp_err      out  1           misaligned-access error (see CONFIGURATION)
//  o_ram_re / o_ram_raddr / i_ram_rdata   out 1 / out RAM_AWIDTH / in XLEN   RAM read side
//  o_ram_we / o_ram_be / o_ram_waddr / o_ram_wdata   out 1 / out 4 / out RAM_AWIDTH / out XLEN   RAM write side
// BEHAVIOUR
//  Reset: state=IDLE, all *_valid / *_ready / o_ram_re / o_ram_we = 0, data outputs = 0, last_grant=DATA.
//  FSM (advances only when clk_en=1): IDLE -> ISSUE -> {WAIT (load/fetch) | RESP (store)}; WAIT -> RESP; RESP -> IDLE.
//  IDLE: req_ready is combinational, high only in IDLE; the granted port sees ready=1 and the other sees ready=0.
//   Only one valid: grant it. Both valid: grant the port not in last_grant. Request is latched at acceptance (cycle T).
//  ISSUE (T+1): exactly one of o_ram_re / o_ram_we pulses for one cycle; address/be/wdata registered.
//  WAIT (T+2): RAM returns data (1-cycle read latency); lane extract + extend; result registered.
//  RESP: rsp_valid held with stable data until rsp_ready=1. Earliest rsp_valid: load/fetch T+3, store T+2.
//   Handshake cycle returns the FSM to IDLE; the next grant happens no earlier than the following cycle.
//  Byte enables: byte be=1<<a[1:0]; half be=3<<a[1:0]; word be=4'hF.
//   wdata replicated (byte x4, half x2) so each lane carries the right bits.
//  Load extract: byte = rdata[8*a[1:0]+:8]; half = rdata[16*a[1]+:16]; sign-extend unless unsigned.
//  Fetch: always word, be unused; a[1:0] ignored.
//  Misaligned without macro: half at a[0]=1 forced to a[1:0]=a[1]0; word forced to a[1:0]=00.
//  Reset mid-transaction: in-flight access dropped, no response; a store already pulsed in ISSUE stays written.
//  clk_en=0: all registers hold, including o_ram_re/o_ram_we levels; ram shares the same clk_en.
// CONFIGURATION
//  MEM_ARB_MISALIGN_TRAP_EN defined:
//   Data request with half at a[0]=1 or word at a[1:0]!=0 is accepted, skips ISSUE/WAIT, goes straight to RESP.
//   Response: o_d_rsp_err=1, rdata=0, no RAM access.
//  Undefined: o_d_rsp_err tied 0; forced-alignment rule above applies.
// STRUCTURE
//  Package mem_pkg: mem_size_e {MEM_B, MEM_H, MEM_W}, arb_state_e {IDLE, ISSUE, WAIT, RESP}, grant_e {GNT_IF, GNT_D}.
//  Sub-module mem_lane_align (combinational): size+a[1:0] -> be, wdata replication, rdata extract/extend, misaligned flag.
// TESTING
//  1 Fetch at 0x8 -> ram_re at T+1 with raddr=2; if_rsp_rdata=mem[2] at T+3.
//  2 SB 0x1AB @0x5 -> ram_we, be=4'b0010, waddr=1, wdata=0xABABABAB.
//    Then LB @0x5 -> 0xFFFFFFAB; LBU @0x5 -> 0x000000AB.
//  3 SH 0x8001 @0x6 -> be=4'b1100; LH @0x6 -> 0xFFFF8001.
//  4 Fetch and data valid in same cycle from reset -> fetch granted first, data next.
//    Both continuously valid -> grants alternate IF, D, IF, D.
//  5 Hold i_d_rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, no new grant.
//    Assert rst during WAIT -> all outputs 0 next cycle, no response issued.
//  6 With MEM_ARB_MISALIGN_TRAP_EN: LW @0x2 -> o_d_rsp_err=1 at T+1, ram_re never asserted.
//    Without it: ram_re with raddr=0, normal data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_pkg;

    typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {GNT_IF, GNT_D} grant_e;

    // Everything about the accepted request that later states still need.
    typedef struct packed {
        grant_e    gnt;
        logic      we;
        mem_size_e size;
        logic [1:0] off;
        logic      unsgn;
    } xfer_t;

    function automatic mem_size_e decode_size(input logic [1:0] s);
        case (s)
            2'd0:    return MEM_B;
            2'd1:    return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

    // Misaligned halves/words are pulled down to their natural boundary.
    function automatic logic [1:0] align_off(input mem_size_e s, input logic [1:0] a);
        case (s)
            MEM_B:   return a;
            MEM_H:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for a request,
// lane extraction and sign/zero extension for returned load data.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_e       req_size,
    input  logic [1:0]      req_addr_lo,
    input  logic [XLEN-1:0] req_wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lane,
    output logic            misaligned,
    input  mem_size_e       rsp_size,
    input  logic [1:0]      rsp_off,
    input  logic            rsp_unsigned,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] rdata_ext
);

    logic [1:0]  req_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign req_off    = align_off(req_size, req_addr_lo);
    assign misaligned = (req_size == MEM_H && req_addr_lo[0]) ||
                        (req_size == MEM_W && req_addr_lo != 2'b00);

    // Replicating the store data lets the RAM pick its lane purely from be.
    always_comb begin
        be         = 4'h0;
        wdata_lane = '0;
        case (req_size)
            MEM_B: begin
                be         = 4'b0001 << req_off;
                wdata_lane = {(XLEN/8){req_wdata[7:0]}};
            end
            MEM_H: begin
                be         = 4'b0011 << req_off;
                wdata_lane = {(XLEN/16){req_wdata[15:0]}};
            end
            default: begin
                be         = 4'hF;
                wdata_lane = req_wdata;
            end
        endcase
    end

    assign byte_sel = rdata[8*rsp_off +: 8];
    assign half_sel = rdata[16*rsp_off[1] +: 16];

    always_comb begin
        rdata_ext = rdata;
        case (rsp_size)
            MEM_B:   rdata_ext = {{(XLEN-8){byte_sel[7] & ~rsp_unsigned}}, byte_sel};
            MEM_H:   rdata_ext = {{(XLEN-16){half_sel[15] & ~rsp_unsigned}}, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-lane RAM between fetch and load/store ports.
// Optional MEM_ARB_MISALIGN_TRAP_EN: misaligned data accesses return an error instead of being aligned.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RAM_AWIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_if_req_valid,
    output logic                  o_if_req_ready,
    input  logic [XLEN-1:0]       i_if_req_addr,
    output logic                  o_if_rsp_valid,
    input  logic                  i_if_rsp_ready,
    output logic [XLEN-1:0]       o_if_rsp_rdata,
    input  logic                  i_d_req_valid,
    output logic                  o_d_req_ready,
    input  logic                  i_d_req_we,
    input  logic [XLEN-1:0]       i_d_req_addr,
    input  logic [1:0]            i_d_req_size,
    input  logic                  i_d_req_unsigned,
    input  logic [XLEN-1:0]       i_d_req_wdata,
    output logic                  o_d_rsp_valid,
    input  logic                  i_d_rsp_ready,
    output logic [XLEN-1:0]       o_d_rsp_rdata,
    output logic                  o_d_rsp_err,
    output logic                  o_ram_re,
    output logic [RAM_AWIDTH-1:0] o_ram_raddr,
    input  logic [XLEN-1:0]       i_ram_rdata,
    output logic                  o_ram_we,
    output logic [3:0]            o_ram_be,
    output logic [RAM_AWIDTH-1:0] o_ram_waddr,
    output logic [XLEN-1:0]       o_ram_wdata
);

    arb_state_e            state, state_nxt;
    grant_e                last_grant;
    xfer_t                 xfer;
    mem_size_e             d_size;
    logic                  if_pick, d_pick, rsp_hs, d_trap, d_err;
    logic                  lane_misaligned;
    logic [3:0]            lane_be;
    logic [XLEN-1:0]       lane_wdata, lane_rdata;
    logic [RAM_AWIDTH-1:0] if_word, d_word;
    logic                  unused_bits;

    assign d_size  = decode_size(i_d_req_size);
    assign if_word = i_if_req_addr[RAM_AWIDTH+1:2];
    assign d_word  = i_d_req_addr[RAM_AWIDTH+1:2];

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .req_size     (d_size),
        .req_addr_lo  (i_d_req_addr[1:0]),
        .req_wdata    (i_d_req_wdata),
        .be           (lane_be),
        .wdata_lane   (lane_wdata),
        .misaligned   (lane_misaligned),
        .rsp_size     (xfer.size),
        .rsp_off      (xfer.off),
        .rsp_unsigned (xfer.unsgn),
        .rdata        (i_ram_rdata),
        .rdata_ext    (lane_rdata)
    );

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    assign d_trap      = lane_misaligned;
    assign o_d_rsp_err = d_err;
    assign unused_bits = ^{i_if_req_addr[XLEN-1:RAM_AWIDTH+2], i_if_req_addr[1:0],
                           i_d_req_addr[XLEN-1:RAM_AWIDTH+2]};
`else
    assign d_trap      = 1'b0;
    assign o_d_rsp_err = 1'b0;
    assign unused_bits = ^{i_if_req_addr[XLEN-1:RAM_AWIDTH+2], i_if_req_addr[1:0],
                           i_d_req_addr[XLEN-1:RAM_AWIDTH+2], lane_misaligned, d_err};
`endif

    // Grant decision; ready doubles as the acceptance strobe, so it is gated by clk_en.
    always_comb begin
        if_pick = 1'b0;
        d_pick  = 1'b0;
        if (state == IDLE && clk_en && !rst) begin
            if (i_if_req_valid && i_d_req_valid) begin
                if (last_grant == GNT_D) if_pick = 1'b1;
                else                     d_pick  = 1'b1;
            end else if (i_if_req_valid) begin
                if_pick = 1'b1;
            end else if (i_d_req_valid) begin
                d_pick = 1'b1;
            end
        end
    end

    assign o_if_req_ready = if_pick;
    assign o_d_req_ready  = d_pick;

    always_comb begin
        state_nxt = state;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (d_pick && d_trap)        state_nxt = RESP;
                else if (if_pick || d_pick)  state_nxt = ISSUE;
            end
            ISSUE: state_nxt = xfer.we ? RESP : WAIT;
            WAIT:  state_nxt = RESP;
            RESP: begin
                rsp_hs = (xfer.gnt == GNT_IF) ? i_if_rsp_ready : i_d_rsp_ready;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         state <= IDLE;
        else if (clk_en) state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= GNT_D;
            xfer           <= '0;
            o_ram_re       <= 1'b0;
            o_ram_raddr    <= '0;
            o_ram_we       <= 1'b0;
            o_ram_be       <= '0;
            o_ram_waddr    <= '0;
            o_ram_wdata    <= '0;
            o_if_rsp_valid <= 1'b0;
            o_if_rsp_rdata <= '0;
            o_d_rsp_valid  <= 1'b0;
            o_d_rsp_rdata  <= '0;
            d_err          <= 1'b0;
        end else if (clk_en) begin
            o_ram_re <= 1'b0;
            o_ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_pick) begin
                        last_grant  <= GNT_IF;
                        xfer        <= '{gnt: GNT_IF, we: 1'b0, size: MEM_W, off: 2'b00, unsgn: 1'b0};
                        o_ram_re    <= 1'b1;
                        o_ram_raddr <= if_word;
                    end else if (d_pick) begin
                        last_grant <= GNT_D;
                        xfer       <= '{gnt: GNT_D, we: i_d_req_we, size: d_size,
                                        off: align_off(d_size, i_d_req_addr[1:0]),
                                        unsgn: i_d_req_unsigned};
                        if (d_trap) begin
                            o_d_rsp_valid <= 1'b1;
                            o_d_rsp_rdata <= '0;
                            d_err         <= 1'b1;
                        end else if (i_d_req_we) begin
                            o_ram_we    <= 1'b1;
                            o_ram_waddr <= d_word;
                            o_ram_be    <= lane_be;
                            o_ram_wdata <= lane_wdata;
                        end else begin
                            o_ram_re    <= 1'b1;
                            o_ram_raddr <= d_word;
                        end
                    end
                end
                ISSUE: begin
                    // Stores complete once the write pulse has gone out.
                    if (xfer.we) begin
                        o_d_rsp_valid <= 1'b1;
                        o_d_rsp_rdata <= '0;
                        d_err         <= 1'b0;
                    end
                end
                WAIT: begin
                    if (xfer.gnt == GNT_IF) begin
                        o_if_rsp_valid <= 1'b1;
                        o_if_rsp_rdata <= i_ram_rdata;
                    end else begin
                        o_d_rsp_valid <= 1'b1;
                        o_d_rsp_rdata <= lane_rdata;
                        d_err         <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        o_if_rsp_valid <= 1'b0;
                        o_d_rsp_valid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
